// File: rtl/progmem_server_pkg.sv
// Shared types and build-time defaults for progmem_server.
// INST_W / INST_ADDR_W may be predefined on the command line; otherwise they default here.
`ifndef INST_W
`define INST_W 32
`endif
`ifndef INST_ADDR_W
`define INST_ADDR_W 6
`endif

package progmem_server_pkg;
  localparam int INST_W_DEF = `INST_W;
  localparam int ADDR_W_DEF = `INST_ADDR_W;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/progmem_server_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr (mod N) wins.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);
  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end
endmodule

// File: rtl/progmem_server.sv
// Program-memory server: streaming boot loader, then round-robin shared fetch service.
// Optional per-core one-entry line buffer enabled by defining PROGMEM_LINE_BUF_EN.
//
// state   | meaning
// ST_LOAD | loader fills RAM, fetches ignored
// ST_RUN  | boot done, fetch ports served
module progmem_server
  import progmem_server_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int INST_W    = INST_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [INST_W-1:0]             ld_data,
  input  logic                          ld_last,
  output logic                          boot_done,
  input  logic [NUM_CORES-1:0]          fetch_req,
  input  logic [NUM_CORES*ADDR_W-1:0]   fetch_addr,
  output logic [NUM_CORES-1:0]          fetch_valid,
  output logic [NUM_CORES*INST_W-1:0]   fetch_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = idx_w(NUM_CORES);

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    wr_ptr, wr_ptr_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic                 mem_we, serve;
  logic [NUM_CORES-1:0] arb_req, grant, hit;
  logic [IDX_W-1:0]     grant_idx;
  logic [ADDR_W-1:0]    rd_addr;
  logic [INST_W-1:0]    mem [DEPTH];
  logic [INST_W-1:0]    rd_q;
  logic [NUM_CORES-1:0] ram_resp, hit_resp;
  logic [INST_W-1:0]    data_hold [NUM_CORES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_LOAD;
      wr_ptr <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rr_ptr_nxt = rr_ptr;
    ld_ready   = 1'b0;
    boot_done  = 1'b0;
    mem_we     = 1'b0;
    serve      = 1'b0;
    case (state)
      ST_LOAD: begin
        ld_ready = en;
        if (ld_valid && en) begin
          mem_we = rst_n;
          // wr_ptr saturates at the last word; that beat also ends the boot
          if (wr_ptr != '1) wr_ptr_nxt = wr_ptr + 1'b1;
          if (ld_last || wr_ptr == '1) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        boot_done = 1'b1;
        serve     = en;
        if (serve && |grant)
          rr_ptr_nxt = (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  assign arb_req = serve ? (fetch_req & ~hit) : '0;

  rr_arbiter #(.N(NUM_CORES), .IDX_W(IDX_W)) u_arb (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (grant[i]) rd_addr = fetch_addr[i*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= ld_data;
    if (|grant) rd_q <= mem[rd_addr];
  end

  // data_hold captures every RAM response even while en=0 so late deliveries stick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_resp <= '0;
      hit_resp <= '0;
      for (int i = 0; i < NUM_CORES; i++) data_hold[i] <= '0;
    end else begin
      ram_resp <= grant;
      hit_resp <= hit;
      for (int i = 0; i < NUM_CORES; i++)
        if (ram_resp[i]) data_hold[i] <= rd_q;
    end
  end

`ifdef PROGMEM_LINE_BUF_EN
  logic [NUM_CORES-1:0] tag_valid;
  logic [ADDR_W-1:0]    tag_addr [NUM_CORES];
  logic [ADDR_W-1:0]    req_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_valid  <= '0;
      req_addr_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) tag_addr[i] <= '0;
    end else begin
      if (|grant) req_addr_q <= rd_addr;
      if (state == ST_LOAD && state_nxt == ST_RUN) begin
        tag_valid <= '0;
      end else begin
        for (int i = 0; i < NUM_CORES; i++)
          if (ram_resp[i]) begin
            tag_valid[i] <= 1'b1;
            tag_addr[i]  <= req_addr_q;
          end
      end
    end
  end

  // compare against the tag as it will stand after this cycle's fill
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CORES; i++)
      hit[i] = serve && fetch_req[i] && (tag_valid[i] || ram_resp[i]) &&
               (fetch_addr[i*ADDR_W +: ADDR_W] == (ram_resp[i] ? req_addr_q : tag_addr[i]));
  end
`else
  assign hit = '0;
`endif

  assign fetch_valid = ram_resp | hit_resp;

  always_comb begin
    fetch_data = '0;
    for (int i = 0; i < NUM_CORES; i++)
      fetch_data[i*INST_W +: INST_W] = ram_resp[i] ? rd_q : data_hold[i];
  end
endmodule

// File: tb/tb_progmem_server.sv
// Self-checking bench for progmem_server: directed literal checks plus randomized traffic vs a behavioural model.
module tb_progmem_server;
  localparam int N     = 2;
  localparam int IW    = progmem_server_pkg::INST_W_DEF;
  localparam int AW    = progmem_server_pkg::ADDR_W_DEF;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n, en, ld_valid, ld_last;
  logic            ld_ready, boot_done;
  logic [IW-1:0]   ld_data;
  logic [N-1:0]    fetch_req, fetch_valid;
  logic [N*AW-1:0] fetch_addr;
  logic [N*IW-1:0] fetch_data;

  progmem_server #(.NUM_CORES(N), .INST_W(IW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .boot_done   (boot_done),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image, boot flag, round-robin pointer, last response per core.
  logic [IW-1:0] m_mem [DEPTH];
  logic [IW-1:0] exp_data [N];
  logic [N-1:0]  exp_valid = '0;
  logic [N-1:0]  consumed  = '0;
  logic [N-1:0]  pend;
  bit            m_run = 1'b0;
  int            m_wp = 0;
  int            m_rr = 0;
  bit            tag_v [N];
  int            tag_a [N];
  bit            granted;
  int            c;

  always @(posedge clk) begin
    consumed = '0;
    if (!rst_n) begin
      m_run = 1'b0; m_wp = 0; m_rr = 0; exp_valid = '0;
      for (int i = 0; i < N; i++) begin exp_data[i] = '0; tag_v[i] = 1'b0; end
    end else begin
      exp_valid = '0;
      if (en) begin
        if (!m_run) begin
          if (ld_valid) begin
            m_mem[m_wp] = ld_data;
            if (ld_last || m_wp == DEPTH - 1) begin
              m_run = 1'b1;
              for (int i = 0; i < N; i++) tag_v[i] = 1'b0;
            end else m_wp++;
          end
        end else begin
          pend = fetch_req;
`ifdef PROGMEM_LINE_BUF_EN
          for (int i = 0; i < N; i++)
            if (fetch_req[i] && tag_v[i] && int'(fetch_addr[i*AW +: AW]) == tag_a[i]) begin
              exp_valid[i] = 1'b1; pend[i] = 1'b0; consumed[i] = 1'b1;
            end
`endif
          granted = 1'b0;
          for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            if (!granted && pend[c]) begin
              granted = 1'b1;
              exp_valid[c] = 1'b1;
              exp_data[c]  = m_mem[fetch_addr[c*AW +: AW]];
              tag_v[c] = 1'b1;
              tag_a[c] = int'(fetch_addr[c*AW +: AW]);
              consumed[c] = 1'b1;
              m_rr = (c + 1) % N;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("boot_done", {63'd0, boot_done}, {63'd0, m_run});
      check("ld_ready", {63'd0, ld_ready}, {63'd0, (!m_run && en)});
      check("fetch_valid", 64'(fetch_valid), 64'(exp_valid));
      for (int i = 0; i < N; i++)
        check($sformatf("fetch_data[%0d]", i), 64'(fetch_data[i*IW +: IW]), 64'(exp_data[i]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int core, input int a);
    fetch_addr[core*AW +: AW] = AW'(a);
  endtask

  function automatic logic [IW-1:0] dword(input int core);
    return fetch_data[core*IW +: IW];
  endfunction

  task automatic load_words(input int cnt);
    int k;
    k = 0;
    while (k < cnt) begin
      en       = ($urandom_range(0, 7) != 0);
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = IW'($urandom);
      ld_last  = (k == cnt - 1);
      if (en && ld_valid) k++;
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0; en = 1'b1;
  endtask

  logic [IW-1:0] words [4];
  logic [N-1:0]  pat;
  int            a1;

  initial begin
    words[0] = IW'(32'h11); words[1] = IW'(32'h22);
    words[2] = IW'(32'h33); words[3] = IW'(32'h44);
    rst_n = 1'b0; en = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    fetch_req = '0; fetch_addr = '0;
    step();
    chk_en = 1'b1;
    step();
    check("rst_boot_done", {63'd0, boot_done}, 64'd0);
    check("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1; ld_data = words[k]; ld_last = (k == 3);
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("boot_after_last", {63'd0, boot_done}, 64'd1);
    check("ld_ready_run", {63'd0, ld_ready}, 64'd0);
    check("model_mem3", 64'(m_mem[3]), 64'h44);

    fetch_req = 2'b01; set_addr(0, 2);
    step();
    check("single_valid", 64'(fetch_valid), 64'h1);
    check("single_data", 64'(dword(0)), 64'h33);
    fetch_req = 2'b00;
    step();
    check("single_idle", 64'(fetch_valid), 64'h0);
    check("single_hold", 64'(dword(0)), 64'h33);

`ifndef PROGMEM_LINE_BUF_EN
    // rr pointer sits at core1 after core0's grant
    fetch_req = 2'b11; set_addr(0, 0); set_addr(1, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      pat = (k % 2 == 0) ? 2'b10 : 2'b01;
      check("contend_valid", 64'(fetch_valid), 64'(pat));
      if (k % 2 == 0) check("contend_d1", 64'(dword(1)), 64'h22);
      else            check("contend_d0", 64'(dword(0)), 64'h11);
    end
    fetch_req = 2'b00;
    step();

    fetch_req = 2'b11;
    step();
    check("en_pre", 64'(fetch_valid), 64'h2);
    en = 1'b0;
    step();
    check("en_off1", 64'(fetch_valid), 64'h0);
    step();
    check("en_off2", 64'(fetch_valid), 64'h0);
    en = 1'b1;
    step();
    check("en_resume", 64'(fetch_valid), 64'h1);
    fetch_req = 2'b00;
    step();
`endif

    rst_n = 1'b0;
    step();
    check("midrst_boot", {63'd0, boot_done}, 64'd0);
    check("midrst_valid", 64'(fetch_valid), 64'h0);
    check("midrst_ld_ready", {63'd0, ld_ready}, 64'd1);
    rst_n = 1'b1;
    ld_valid = 1'b1; ld_data = IW'(32'hAA); ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    fetch_req = 2'b01; set_addr(0, 0);
    step();
    check("reload_data", 64'(dword(0)), 64'hAA);
    fetch_req = 2'b00;
    step();

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      ld_valid = 1'b1; ld_data = IW'(32'hC000_0000 | k); ld_last = 1'b0;
      if (k == DEPTH - 1) check("full_pre_boot", {63'd0, boot_done}, 64'd0);
      step();
    end
    check("full_boot", {63'd1 & 63'd0, boot_done}, 64'd1);
    ld_data = IW'(32'hDEAD);
    step();
    ld_valid = 1'b0;
    fetch_req = 2'b10; set_addr(1, DEPTH - 1);
    step();
    check("full_last_valid", 64'(fetch_valid), 64'h2);
    check("full_last_data", 64'(dword(1)), 64'(IW'(32'hC000_0000 | (DEPTH - 1))));
    fetch_req = 2'b00;
    step();

`ifdef PROGMEM_LINE_BUF_EN
    fetch_req = 2'b11; set_addr(0, 1); a1 = 2; set_addr(1, a1);
    for (int k = 0; k < 7; k++) begin
      step();
      if (consumed[1]) begin a1 = (a1 + 1) % DEPTH; set_addr(1, a1); end
      if (k >= 4) begin
        check("lb_both_valid", 64'(fetch_valid), 64'h3);
        check("lb_core0_data", 64'(dword(0)), 64'(IW'(32'hC000_0001)));
      end
    end
    fetch_req = 2'b00;
    step();
`endif

    for (int r = 0; r < 4; r++) begin
      for (int cyc = 0; cyc < 800; cyc++) begin
        en = ($urandom_range(0, 9) != 0);
        for (int i = 0; i < N; i++)
          if (!fetch_req[i] || consumed[i]) begin
            fetch_req[i] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) set_addr(i, $urandom_range(0, 3));
            else set_addr(i, $urandom_range(0, DEPTH - 1));
          end
        step();
      end
      en = 1'b1; fetch_req = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      load_words($urandom_range(1, DEPTH));
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
